// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute immediate bus: instruction/PC in, {fmt, imm, target} out, valid/ready both sides.
// out_illegal/illegal_cnt exist only when IMM_GEN_ILLEGAL_CNT_EN is defined.
interface imm_gen_pipe_if #(
  parameter int XLEN = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  logic            out_illegal;
  logic [15:0]     illegal_cnt;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_fmt, out_imm, out_target, out_illegal, illegal_cnt
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_fmt, out_imm, out_target, out_illegal, illegal_cnt
  );
`else
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_fmt, out_imm, out_target
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_fmt, out_imm, out_target
  );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// RV64I immediate/target generator with DEPTH-entry output FIFO; 1-cycle latency, in_ready = !full (no path from out_ready).
// IMM_GEN_ILLEGAL_CNT_EN adds out_illegal and a saturating 16-bit count of accepted INV instructions.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  imm_gen_pipe_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_INV = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          new_entry;
  entry_t          head;
  logic [31:0]     raw32;
  logic            sgn;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // raw32 is the 32-bit sign-extended immediate; widened to XLEN below from its top bit
  always_comb begin
    sgn           = bus.in_instr[31];
    raw32         = '0;
    new_entry.fmt = FMT_INV;
    case (bus.in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        new_entry.fmt = FMT_I;
        raw32 = {{20{sgn}}, bus.in_instr[31:20]};
      end
      7'b0100011: begin
        new_entry.fmt = FMT_S;
        raw32 = {{20{sgn}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      end
      7'b1100011: begin
        new_entry.fmt = FMT_B;
        raw32 = {{19{sgn}}, bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25],
                 bus.in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        new_entry.fmt = FMT_U;
        raw32 = {bus.in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        new_entry.fmt = FMT_J;
        raw32 = {{11{sgn}}, bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20],
                 bus.in_instr[30:21], 1'b0};
      end
      default: begin
        new_entry.fmt = FMT_INV;
        raw32 = '0;
      end
    endcase
    new_entry.imm    = {{(XLEN-31){raw32[31]}}, raw32[30:0]};
    new_entry.target = bus.in_pc + new_entry.imm;
  end

  assign bus.in_ready  = (count_q != CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign head           = mem_q[rd_ptr_q];
  assign bus.out_fmt    = bus.out_valid ? head.fmt    : '0;
  assign bus.out_imm    = bus.out_valid ? head.imm    : '0;
  assign bus.out_target = bus.out_valid ? head.target : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: outputs are masked while count is zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef IMM_GEN_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (push && (new_entry.fmt == FMT_INV) && (illegal_cnt_q != 16'hFFFF)) begin
      illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      illegal_cnt_q <= '0;
    end else begin
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.illegal_cnt = illegal_cnt_q;
  assign bus.out_illegal = bus.out_valid && (head.fmt == FMT_INV);
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe (XLEN=64, DEPTH=2): vector table through a scoreboard plus backpressure/reset sequences.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(64)) bus ();

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_ill  = 0;
  bit   mon_en   = 1'b0;
  vec_t vt[16];

  function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] pc,
                              input logic [2:0] fmt, input logic [63:0] imm, input logic [63:0] tgt);
    vec_t v;
    v.instr = instr; v.pc = pc; v.e.fmt = fmt; v.e.imm = imm; v.e.tgt = tgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input vec_t v);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = v.instr;
    bus.in_pc    = v.pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(v.e);
        if (v.e.fmt == 3'd0 && exp_ill < 65535) exp_ill++;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL push_timeout instr=0x%0h in_ready stayed 0, required 1", v.instr);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: head must match queue front; a transfer pops it.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out fmt=%0d imm=0x%0h required no entry", bus.out_fmt, bus.out_imm);
        end else begin
          e = sb[0];
          check("out_fmt", 64'(bus.out_fmt), 64'(e.fmt));
          check("out_imm", bus.out_imm, e.imm);
          check("out_target", bus.out_target, e.tgt);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
          check("out_illegal", 64'(bus.out_illegal), 64'(e.fmt == 3'd0));
`endif
          if (bus.out_ready) void'(sb.pop_front());
        end
      end else begin
        check("empty_fmt_zero", 64'(bus.out_fmt), 64'd0);
        check("empty_imm_zero", bus.out_imm, 64'd0);
        check("empty_tgt_zero", bus.out_target, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t a, b, c, x;
    vt[0]  = mk(32'hFFF00093, 64'h1000, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFF);
    vt[1]  = mk(32'hFE113C23, 64'h1000, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0FF8);
    vt[2]  = mk(32'h00000463, 64'h1000, 3'd3, 64'h8, 64'h1008);
    vt[3]  = mk(32'hFFDFF06F, 64'h1000, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0FFC);
    vt[4]  = mk(32'h123452B7, 64'h1000, 3'd4, 64'h1234_5000, 64'h1234_6000);
    vt[5]  = mk(32'h800002B7, 64'h1000, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_1000);
    vt[6]  = mk(32'h0000007F, 64'h1000, 3'd0, 64'h0, 64'h1000);
    vt[7]  = mk(32'h00500513, 64'h1000, 3'd1, 64'h5, 64'h1005);
    vt[8]  = mk(32'h00001517, 64'h2000, 3'd4, 64'h1000, 64'h3000);
    vt[9]  = mk(32'h00813083, 64'h0010, 3'd1, 64'h8, 64'h0018);
    vt[10] = mk(32'h000080E7, 64'h4000, 3'd1, 64'h0, 64'h4000);
    vt[11] = mk(32'h00000073, 64'h0100, 3'd1, 64'h0, 64'h0100);
    vt[12] = mk(32'h0010009B, 64'h0200, 3'd1, 64'h1, 64'h0201);
    vt[13] = mk(32'h00800093, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 64'h8, 64'h4);
    vt[14] = mk(32'hFE000EE3, 64'h1000, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0FFC);
    vt[15] = mk(32'h00000000, 64'h1234, 3'd0, 64'h0, 64'h1234);

    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_fmt", 64'(bus.out_fmt), 64'd0);
    check("rst_out_imm", bus.out_imm, 64'd0);
    check("rst_out_target", bus.out_target, 64'd0);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    check("rst_illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
`endif
    @(posedge clk); #1;
    mon_en = 1'b1;

    // First accept while empty: not visible same cycle, visible next cycle.
    a = vt[7];
    bus.in_valid = 1'b1; bus.in_instr = a.instr; bus.in_pc = a.pc;
    @(negedge clk);
    check("no_bypass_valid", 64'(bus.out_valid), 64'd0);
    check("empty_in_ready", 64'(bus.in_ready), 64'd1);
    sb.push_back(a.e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("latency1_valid", 64'(bus.out_valid), 64'd1);
    check("latency1_imm", bus.out_imm, 64'h5);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // Format table, back-to-back with out_ready high.
    for (int i = 0; i < 16; i++) push(vt[i]);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: third push blocked, head held, then in-order drain.
    a = vt[7]; b = vt[0]; c = vt[4];
    bus.out_ready = 1'b0;
    push(a);
    push(b);
    bus.in_instr = c.instr; bus.in_pc = c.pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      check("bp_hold_imm", bus.out_imm, a.e.imm);
      check("bp_hold_target", bus.out_target, a.e.tgt);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("no_comb_ready", 64'(bus.in_ready), 64'd0);
    push(c);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("drain_b2b_valid", 64'(bus.out_valid), 64'd1);
    check("drain_b2b_imm", bus.out_imm, c.e.imm);
    drain();

    // Reset mid-stream with two entries buffered and an INV presented.
    bus.out_ready = 1'b0;
    push(vt[6]);
    push(vt[1]);
    x = vt[6];
    bus.in_instr = x.instr; bus.in_pc = x.pc;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    sb.delete();
    exp_ill = 0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    check("midrst_illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
`endif
    @(posedge clk); #1;

    // Input presented during the reset cycle must be dropped.
    a = vt[7];
    bus.in_valid = 1'b1; bus.in_instr = a.instr; bus.in_pc = a.pc;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_cycle_no_accept", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // Three INV pushes: imm=0, target=pc, counter reaches 3.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(32'h0000007F, 64'h1000, 3'd0, 64'h0, 64'h1000));
    bus.in_valid = 1'b0;
    drain();
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    check("illegal_cnt_3", 64'(bus.illegal_cnt), 64'd3);
    check("illegal_cnt_model", 64'(bus.illegal_cnt), 64'(exp_ill));
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, elastic immediate generator for the RV64I decode path. It accepts one instruction and PC per cycle over a valid/ready handshake and classifies the format (I/S/B/U/J/invalid). It produces the sign-extended XLEN immediate, with correct bit-0 handling for B/J and the 12-bit shift for U, plus the PC-relative target. Results are buffered in a DEPTH-entry FIFO so decode can absorb execute-stage stalls.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64.
- DEPTH, 2: output FIFO entries; legal range 1..8.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instruction/PC presented.
- in_ready  out  1  block can accept; equals !full.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer accepts head.
- out_fmt  out  3  0=INV, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_imm  out  XLEN  sign-extended immediate.
- out_target  out  XLEN  in_pc + imm, modulo 2^XLEN.
- out_illegal  out  1  present only with IMM_GEN_ILLEGAL_CNT_EN.
- illegal_cnt  out  16  present only with IMM_GEN_ILLEGAL_CNT_EN.

## Operation
- Decode on opcode in_instr[6:0]:
  - I (0000011, 0010011, 0011011, 1100111, 1110011): sext(instr[31:20]).
  - S (0100011): sext({instr[31:25], instr[11:7]}).
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (0110111, 0010111): sext({instr[31:12], 12'b0}).
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode: fmt=INV, imm=0, target=in_pc.
- Sign extension always uses instr[31], replicated to XLEN.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- The FIFO stores {fmt, imm, target}. Write and read pointers wrap modulo DEPTH. Occupancy is held in a count register of width clog2(DEPTH+1).
- Full: count==DEPTH, in_ready=0. A simultaneous pop does not open in_ready in the same cycle; there is no combinational ready path from out_ready.
- Empty: count==0, out_valid=0, and out_fmt/out_imm/out_target are forced to 0.
- Simultaneous push and pop while not full and not empty: count unchanged, both pointers advance.
- Push while empty: data visible at the output on the next cycle. There is no same-cycle bypass.
- Holding rule: while out_valid && !out_ready, the output fields must stay stable.

## Timing
- Latency: 1 cycle from accepted input to out_valid when the FIFO is empty.
- Throughput: 1 entry per cycle sustained when out_ready is held high.
- Reset (reset_n=0 sampled at a clk edge):
  - count=0, pointers=0.
  - in_ready=1 on the following cycle; out_valid=0; all data outputs 0.
  - illegal_cnt=0 and out_illegal=0.
- Reset asserted mid-stream discards all buffered entries. Inputs presented in the reset cycle are not accepted.
- All outputs are registered or derived only from registered state.

## Configuration
- IMM_GEN_ILLEGAL_CNT_EN defined:
  - Adds ports out_illegal and illegal_cnt.
  - out_illegal is high alongside a head entry whose fmt==INV.
  - illegal_cnt increments on each accepted push with fmt INV and saturates at 16'hFFFF.
- Undefined: ports and counter are absent; INV entries still flow through with imm=0.

## Test plan
- Format checks, in_pc=0x1000, out_ready=1:
  - 0xFFF00093 (addi x1,x0,-1) → fmt=1, imm=0xFFFF_FFFF_FFFF_FFFF, target=0xFFF.
  - 0xFE113C23 (sd x1,-8(x2)) → fmt=2, imm=0xFFFF_FFFF_FFFF_FFF8.
- B/J, in_pc=0x1000:
  - 0x00000463 (beq +8) → fmt=3, imm=8, target=0x1008.
  - 0xFFDFF06F (jal -4) → fmt=5, imm=-4, target=0xFFC.
- U: 0x123452B7 (lui) → fmt=4, imm=0x0000_0000_1234_5000. 0x800002B7 → imm=0xFFFF_FFFF_8000_0000.
- Backpressure, DEPTH=2: out_ready=0, push 3 back-to-back. in_ready drops after 2 accepts. Output holds the first entry stable. Release out_ready: entries drain in order, 1 per cycle.
- Reset mid-stream: with 2 entries buffered, pulse reset_n low for 1 cycle. Next cycle out_valid=0, in_ready=1, and illegal_cnt=0 (if enabled).
- Invalid/counter (macro on): push 0x0000007F three times → fmt=0, imm=0, out_illegal=1 per entry, illegal_cnt=3.
